sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
- Shares one single-port 1024x32 SRAM macro between two requesters, A and B.
- The macro has one RW port: read data appears one cycle after an enabled read and is held until the next read.
- After reset, the block sweeps the whole array to a known value. It then arbitrates read/write requests round-robin and returns read data on a per-requester response channel.
- Sits between the cache/table logic (requesters) and the generated memory wrapper.

Parameters:
- ADDR_W, 10, address width; DEPTH = 2^ADDR_W.
- DATA_W, 32, data width.
- INIT_EN, 1, 1 = run the clear sweep after reset; 0 = go straight to ARB.
- INIT_VALUE, 0, word written to every entry during the sweep.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- a_req_valid  in  1  requester A presents a request.
- a_req_ready  out  1  A's request is accepted this cycle.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  ADDR_W  request address.
- a_req_wdata  in  DATA_W  write data.
- a_resp_valid  out  1  A read data valid (one-cycle pulse, no backpressure).
- a_resp_rdata  out  DATA_W  A read data.
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_wdata, b_resp_valid, b_resp_rdata: same as the A ports, for requester B.
- mem_en  out  1  macro enable.
- mem_wmode  out  1  macro write mode.
- mem_addr  out  ADDR_W  macro address.
- mem_wdata  out  DATA_W  macro write data.
- mem_rdata  in  DATA_W  macro read data (valid one cycle after an enabled read).
- init_done  out  1  sweep complete; arbitration active.

Behaviour:
- Reset (reset_n=0 at edge):
  - state=INIT (ARB if INIT_EN=0), sweep counter=0, last_grant=B.
  - init_done=0; both resp_valid=0; mem_en=0 during the reset cycle.
  - Applies mid-operation: any in-flight read response is dropped and the sweep restarts at 0.
- INIT:
  - Each cycle: mem_en=1, mem_wmode=1, mem_addr=counter, mem_wdata=INIT_VALUE; counter increments.
  - Both req_ready=0 throughout.
  - After the write at address DEPTH-1, go to ARB. init_done=1 from the next cycle; sweep takes exactly DEPTH cycles.
  - Counter is ADDR_W+1 bits so the terminal compare does not wrap.
- ARB grant (combinational from the current-cycle valids):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester not equal to last_grant.
  - last_grant updates to the granted requester on every grant.
  - x_req_ready = grant_x; at most one ready per cycle; ready never asserts without valid.
- Macro drive on grant: mem_en=1, mem_wmode=x_req_write, mem_addr/mem_wdata from the granted requester. No grant -> mem_en=0; addr/wdata don't-care.
- Read response:
  - A registered tag records {read granted, owner}.
  - The next cycle, owner_resp_valid=1 and owner_resp_rdata=mem_rdata (passthrough). The other requester's resp_valid=0.
  - Writes produce no response.
  - Full throughput: one request per cycle, back-to-back reads give back-to-back responses.
- Ordering:
  - Write then read of the same address in consecutive cycles -> the read returns the new data.
  - Read then write of the same address in consecutive cycles -> the read returns the old data.
- resp_rdata is don't-care when resp_valid=0; the bench checks it only under valid.
- No internal buffering: a requester holds valid/addr/data stable until it sees ready.

Test Plan:
- Reset then idle; INIT_EN=1, INIT_VALUE=0 -> mem_en high for exactly 1024 cycles with addresses 0..1023 in order; init_done rises on cycle 1025; readies stay 0 throughout.
- After init: A writes 0xDEADBEEF to addr 5; next cycle A reads addr 5 -> a_resp_valid pulses one cycle after the read grant with 0xDEADBEEF; b_resp_valid stays 0.
- A and B both hold read requests (A addr 1, B addr 2) for 4 cycles -> grants A,B,A,B; responses alternate with a one-cycle lag; last_grant ends at B.
- B write to addr 7 in cycle N and A read of addr 7 in cycle N+1 -> A receives B's data; A read of addr 9 in cycle M and B write to addr 9 in cycle M+1 -> A receives the prior value (0 after init).
- reset_n asserted the cycle after an A read grant -> no a_resp_valid; sweep restarts at address 0; init_done=0.
- INIT_EN=0 -> init_done=1 the first cycle after reset release; the first request is granted immediately, and A wins when both are valid.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port SRAM macro between requesters A and B. After reset it
// optionally sweeps the array to INIT_VALUE, then arbitrates round-robin with a one-cycle read response.
module sram_1rw_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int INIT_EN = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_resp_valid,
  output logic [DATA_W-1:0] a_resp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_resp_valid,
  output logic [DATA_W-1:0] b_resp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done,
  output logic              dbg_state
);

  // Handshake: a request transfers in any cycle where x_req_valid && x_req_ready;
  // ready is purely a grant and never asserts without valid. Responses have no backpressure.

  typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   sweep_cnt;
  logic              last_grant;
  logic              grant_a, grant_b;
  logic              arb_en;
  logic              tag_valid, tag_owner;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= (INIT_EN != 0) ? ST_INIT : ST_ARB;
    else          state <= state_nxt;
  end

  // Next-state logic: the sweep ends after writing the last address
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && sweep_cnt == LAST_IDX) state_nxt = ST_ARB;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)               sweep_cnt <= '0;
    else if (state == ST_INIT)  sweep_cnt <= sweep_cnt + 1'b1;
  end

  // Round-robin: on contention the requester not served last wins
  assign arb_en  = reset_n && (state == ST_ARB);
  assign grant_a = arb_en && a_req_valid && (!b_req_valid || last_grant == OWNER_B);
  assign grant_b = arb_en && b_req_valid && (!a_req_valid || last_grant == OWNER_A);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant <= OWNER_B;
      tag_valid  <= 1'b0;
      tag_owner  <= OWNER_A;
    end else begin
      if (grant_a)      last_grant <= OWNER_A;
      else if (grant_b) last_grant <= OWNER_B;
      tag_valid <= (grant_a && !a_req_write) || (grant_b && !b_req_write);
      tag_owner <= grant_b ? OWNER_B : OWNER_A;
    end
  end

  // Output logic
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n && state == ST_INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = sweep_cnt[ADDR_W-1:0];
      mem_wdata = INIT_VALUE;
    end else if (grant_a) begin
      mem_en    = 1'b1;
      mem_wmode = a_req_write;
      mem_addr  = a_req_addr;
      mem_wdata = a_req_wdata;
    end else if (grant_b) begin
      mem_en    = 1'b1;
      mem_wmode = b_req_write;
      mem_addr  = b_req_addr;
      mem_wdata = b_req_wdata;
    end
  end

  assign a_req_ready  = grant_a;
  assign b_req_ready  = grant_b;
  assign a_resp_valid = reset_n && tag_valid && (tag_owner == OWNER_A);
  assign b_resp_valid = reset_n && tag_valid && (tag_owner == OWNER_B);
  assign a_resp_rdata = mem_rdata;
  assign b_resp_rdata = mem_rdata;
  assign init_done    = arb_en;
  assign dbg_state    = state;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: SRAM macro model, reference-memory scoreboard checked
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_sram_1rw_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main DUT (sweep enabled)
  logic reset_n;
  logic a_req_valid, a_req_ready, a_req_write, a_resp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_resp_rdata;
  logic b_req_valid, b_req_ready, b_req_write, b_resp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_resp_rdata;
  logic mem_en, mem_wmode, init_done, dbg_state;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Second DUT without the sweep
  logic n_reset_n;
  logic n_a_req_valid, n_a_req_ready, n_a_req_write, n_a_resp_valid;
  logic [AW-1:0] n_a_req_addr;
  logic [DW-1:0] n_a_req_wdata, n_a_resp_rdata;
  logic n_b_req_valid, n_b_req_ready, n_b_req_write, n_b_resp_valid;
  logic [AW-1:0] n_b_req_addr;
  logic [DW-1:0] n_b_req_wdata, n_b_resp_rdata;
  logic n_mem_en, n_mem_wmode, n_init_done, n_dbg_state;
  logic [AW-1:0] n_mem_addr;
  logic [DW-1:0] n_mem_wdata;
  logic [DW-1:0] n_mem_rdata = '0;

  sram_1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1), .INIT_VALUE(32'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done), .dbg_state(dbg_state)
  );

  sram_1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(0), .INIT_VALUE(32'h0)) dut_noinit (
    .clock(clock), .reset_n(n_reset_n),
    .a_req_valid(n_a_req_valid), .a_req_ready(n_a_req_ready), .a_req_write(n_a_req_write),
    .a_req_addr(n_a_req_addr), .a_req_wdata(n_a_req_wdata),
    .a_resp_valid(n_a_resp_valid), .a_resp_rdata(n_a_resp_rdata),
    .b_req_valid(n_b_req_valid), .b_req_ready(n_b_req_ready), .b_req_write(n_b_req_write),
    .b_req_addr(n_b_req_addr), .b_req_wdata(n_b_req_wdata),
    .b_resp_valid(n_b_resp_valid), .b_resp_rdata(n_b_resp_rdata),
    .mem_en(n_mem_en), .mem_wmode(n_mem_wmode), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_rdata(n_mem_rdata), .init_done(n_init_done), .dbg_state(n_dbg_state)
  );

  // Single-port macro: read data registered on an enabled read, held otherwise
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) sram[mem_addr] <= mem_wdata;
      else           mem_rdata <= sram[mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as seen by accepted requests
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_init = 1'b0;
  int            m_idx = 0;
  bit            m_last_b = 1'b1;
  bit            m_pend_a = 1'b0, m_pend_b = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  int            cyc = 0, done_cyc = 0, sweep_en_cnt = 0;
  logic [DW:0]   resp_q[$];
  logic [DW:0]   exp_q[$];
  int            grant_q[$];

  always @(negedge clock) begin : cmp
    int g;
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [DW-1:0] r_wd;
    if (!reset_n) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_a_resp_valid", a_resp_valid, 0);
      chk("rst_b_resp_valid", b_resp_valid, 0);
      chk("rst_a_ready", a_req_ready, 0);
      chk("rst_b_ready", b_req_ready, 0);
      m_init = 1'b1; m_idx = 0; m_last_b = 1'b1;
      m_pend_a = 1'b0; m_pend_b = 1'b0;
      cyc = 0; done_cyc = 0; sweep_en_cnt = 0;
    end else begin
      cyc++;
      if (init_done && done_cyc == 0) done_cyc = cyc;
      if (mem_en && !init_done) sweep_en_cnt++;
      chk("a_resp_valid", a_resp_valid, m_pend_a);
      chk("b_resp_valid", b_resp_valid, m_pend_b);
      if (m_pend_a) chk("a_resp_rdata", a_resp_rdata, m_pend_data);
      if (m_pend_b) chk("b_resp_rdata", b_resp_rdata, m_pend_data);
      if (a_resp_valid) resp_q.push_back({1'b0, a_resp_rdata});
      if (b_resp_valid) resp_q.push_back({1'b1, b_resp_rdata});
      m_pend_a = 1'b0; m_pend_b = 1'b0;
      if (m_init) begin
        chk("init_done_low", init_done, 0);
        chk("sweep_mem_en", mem_en, 1);
        chk("sweep_wmode", mem_wmode, 1);
        chk("sweep_addr", mem_addr, m_idx);
        chk("sweep_wdata", mem_wdata, 32'h0);
        chk("sweep_a_ready", a_req_ready, 0);
        chk("sweep_b_ready", b_req_ready, 0);
        ref_mem[m_idx] = 32'h0;
        m_idx++;
        if (m_idx == DEPTH) m_init = 1'b0;
      end else begin
        chk("init_done_high", init_done, 1);
        g = 0;
        if (a_req_valid && b_req_valid) g = m_last_b ? 1 : 2;
        else if (a_req_valid)           g = 1;
        else if (b_req_valid)           g = 2;
        chk("a_req_ready", a_req_ready, g == 1);
        chk("b_req_ready", b_req_ready, g == 2);
        chk("mem_en", mem_en, g != 0);
        if (g != 0) begin
          r_addr = (g == 1) ? a_req_addr  : b_req_addr;
          r_wr   = (g == 1) ? a_req_write : b_req_write;
          r_wd   = (g == 1) ? a_req_wdata : b_req_wdata;
          chk("mem_wmode", mem_wmode, r_wr);
          chk("mem_addr", mem_addr, r_addr);
          if (r_wr) begin
            chk("mem_wdata", mem_wdata, r_wd);
            ref_mem[r_addr] = r_wd;
          end else begin
            m_pend_a = (g == 1);
            m_pend_b = (g == 2);
            m_pend_data = ref_mem[r_addr];
          end
          m_last_b = (g == 2);
          grant_q.push_back(g);
        end
      end
    end
  end

  task automatic step(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req_valid = av; a_req_write = aw; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_write = bw; b_req_addr = ba; b_req_wdata = bd;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_init(input int limit);
    for (int i = 0; i < limit && !init_done; i++) @(negedge clock);
    chk("init_wait_bound", init_done, 1);
    @(posedge clock); #1;
  endtask

  task automatic check_resps(input string name);
    chk({name, "_count"}, resp_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
      chk({name, "_resp"}, resp_q[i][DW-1:0] ^ {DW{resp_q[i][DW]}}, exp_q[i][DW-1:0] ^ {DW{exp_q[i][DW]}});
    for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
      chk({name, "_owner"}, resp_q[i][DW], exp_q[i][DW]);
    resp_q.delete();
    exp_q.delete();
    grant_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; n_reset_n = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
    n_a_req_valid = 0; n_a_req_write = 0; n_a_req_addr = 0; n_a_req_wdata = 0;
    n_b_req_valid = 0; n_b_req_write = 0; n_b_req_addr = 0; n_b_req_wdata = 0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1; n_reset_n = 1'b1;
    n_a_req_valid = 1; n_a_req_addr = 10'd3;
    n_b_req_valid = 1; n_b_req_addr = 10'd4;

    // No-sweep instance: arbitration live on the first cycle, A wins first contention
    @(negedge clock);
    chk("noinit_done", n_init_done, 1);
    chk("noinit_a_ready", n_a_req_ready, 1);
    chk("noinit_b_ready", n_b_req_ready, 0);
    chk("noinit_mem_en", n_mem_en, 1);
    chk("noinit_addr", n_mem_addr, 10'd3);
    @(posedge clock); #1;
    @(negedge clock);
    chk("noinit_b_second", n_b_req_ready, 1);
    chk("noinit_a_second", n_a_req_ready, 0);
    chk("noinit_addr2", n_mem_addr, 10'd4);
    @(posedge clock); #1;
    n_a_req_valid = 0; n_b_req_valid = 0;

    // Sweep: 1024 enabled cycles, init_done on cycle 1025
    wait_init(1100);
    chk("sweep_len", sweep_en_cnt, 1024);
    chk("init_done_cycle", done_cyc, 1025);
    resp_q.delete(); grant_q.delete();

    // Write then read back on A
    step(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 10'd5, 0, 0, 0, 0, 0);
    idle(2);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    check_resps("a_wr_rd");

    // Contention: four cycles of both reading
    step(1, 1, 10'd1, 32'h11111111, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10'd2, 32'h22222222);
    idle(1);
    grant_q.delete();
    for (int i = 0; i < 4; i++) step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0);
    idle(2);
    chk("rr_grants", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      chk("rr_g0", grant_q[0], 1);
      chk("rr_g1", grant_q[1], 2);
      chk("rr_g2", grant_q[2], 1);
      chk("rr_g3", grant_q[3], 2);
    end
    exp_q.push_back({1'b0, 32'h11111111});
    exp_q.push_back({1'b1, 32'h22222222});
    exp_q.push_back({1'b0, 32'h11111111});
    exp_q.push_back({1'b1, 32'h22222222});
    check_resps("rr");
    step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0);
    idle(2);
    chk("rr_last_b", grant_q.size() > 0 ? grant_q[0] : 0, 1);
    exp_q.push_back({1'b0, 32'h11111111});
    check_resps("rr_after");

    // B write then A read of same address; A read then B write of another
    step(0, 0, 0, 0, 1, 1, 10'd7, 32'hB0B00007);
    step(1, 0, 10'd7, 0, 0, 0, 0, 0);
    idle(2);
    exp_q.push_back({1'b0, 32'hB0B00007});
    check_resps("wr_then_rd");
    step(1, 0, 10'd9, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10'd9, 32'h99999999);
    idle(2);
    exp_q.push_back({1'b0, 32'h00000000});
    check_resps("rd_then_wr");

    // Reset the cycle after an A read grant: response dropped, sweep restarts
    step(1, 0, 10'd5, 0, 0, 0, 0, 0);
    a_req_valid = 0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_a_resp", a_resp_valid, 0);
    chk("midrst_init_done", init_done, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("restart_addr", mem_addr, 10'd0);
    chk("restart_mem_en", mem_en, 1);
    chk("restart_init_done", init_done, 0);
    chk("restart_resp_count", resp_q.size(), 0);
    wait_init(1100);
    chk("restart_init_done_cycle", done_cyc, 1025);
    step(1, 0, 10'd5, 0, 0, 0, 0, 0);
    idle(2);
    exp_q.push_back({1'b0, 32'h00000000});
    check_resps("after_resweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
